// File: rtl/fft_mdc_stage.sv
//==============================================================================
// Module : fft_mdc_stage
// Desc   : One radix-2 stage of a 2-parallel MDC FFT: delay-commutator, butterfly,
//          twiddle multiply, saturation. Define FFT_STAGE_ROUND_EN for round-half-up.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fft_mdc_stage #(
    parameter int NBITS_IN    = 12,
    parameter int NBITS_COEFF = 11,
    parameter int NBITS_OUT   = 15,
    parameter int DELAY       = 16,
    parameter int TW_AW       = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [2*NBITS_IN-1:0]    in_up,
    input  logic [2*NBITS_IN-1:0]    in_down,
    output logic [TW_AW-1:0]         tw_addr,
    input  logic [2*NBITS_COEFF-1:0] tw_coeff,
    output logic                     out_valid,
    output logic [2*NBITS_OUT-1:0]   out_up,
    output logic [2*NBITS_OUT-1:0]   out_down,
    output logic                     ovf
);

    localparam int c_coeff_frac = NBITS_COEFF - 2;
    localparam int c_cnt_w      = $clog2(DELAY) + 1;
    localparam int c_bf_w       = NBITS_IN + 1;
    localparam int c_prod_w     = c_bf_w + NBITS_COEFF + 1;
    localparam int c_sat_w      = (c_prod_w > NBITS_OUT) ? c_prod_w : NBITS_OUT + 1;
    localparam logic signed [c_sat_w-1:0] c_max =
        {{(c_sat_w-NBITS_OUT+1){1'b0}}, {(NBITS_OUT-1){1'b1}}};
    localparam logic signed [c_sat_w-1:0] c_min = ~c_max;
`ifdef FFT_STAGE_ROUND_EN
    localparam logic signed [c_prod_w-1:0] c_rnd = c_prod_w'(2**(c_coeff_frac-1));
`else
    localparam logic signed [c_prod_w-1:0] c_rnd = c_prod_w'(0);
`endif

    // Returns {saturated_flag, clamped value}
    function automatic logic [NBITS_OUT:0] f_sat(input logic signed [c_sat_w-1:0] v);
        if (v > c_max)
            f_sat = {1'b1, c_max[NBITS_OUT-1:0]};
        else if (v < c_min)
            f_sat = {1'b1, c_min[NBITS_OUT-1:0]};
        else
            f_sat = {1'b0, v[NBITS_OUT-1:0]};
    endfunction

    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_primed;
    logic [TW_AW-1:0]      r_tw_addr;
    logic                  r_v1;
    logic [2*NBITS_IN-1:0] r_low_dl [DELAY];
    logic [2*NBITS_IN-1:0] r_up_dl  [DELAY];
    logic                  w_en;
    logic                  w_sel;
    logic [2*NBITS_IN-1:0] w_low_d, w_sw_up, w_sw_lo, w_c_up, w_c_lo;

    // Delay lines only move on accepted samples; a sample coinciding with rst is dropped
    assign w_en    = in_valid & ~rst;
    assign w_sel   = r_cnt[c_cnt_w-1];
    assign w_low_d = r_low_dl[DELAY-1];
    assign w_sw_up = w_sel ? w_low_d : in_up;
    assign w_sw_lo = w_sel ? in_up : w_low_d;
    assign w_c_up  = r_up_dl[DELAY-1];
    assign w_c_lo  = w_sw_lo;

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_low_dl[0] <= in_down;
            r_up_dl[0]  <= w_sw_up;
            for (int i = 1; i < DELAY; i++) begin
                r_low_dl[i] <= r_low_dl[i-1];
                r_up_dl[i]  <= r_up_dl[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_primed  <= 1'b0;
            r_tw_addr <= '0;
            r_v1      <= 1'b0;
        end else begin
            r_v1 <= in_valid & r_primed;
            if (in_valid) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(DELAY-1))
                    r_primed <= 1'b1;
                if (r_primed)
                    r_tw_addr <= r_tw_addr + TW_AW'(1);
            end
        end
    end

    logic signed [c_bf_w-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [c_bf_w-1:0] r_bf_up_re, r_bf_up_im, r_bf_dn_re, r_bf_dn_im;

    assign w_a_re = c_bf_w'($signed(w_c_up[2*NBITS_IN-1 -: NBITS_IN]));
    assign w_a_im = c_bf_w'($signed(w_c_up[NBITS_IN-1:0]));
    assign w_b_re = c_bf_w'($signed(w_c_lo[2*NBITS_IN-1 -: NBITS_IN]));
    assign w_b_im = c_bf_w'($signed(w_c_lo[NBITS_IN-1:0]));

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_bf_up_re <= w_a_re + w_b_re;
            r_bf_up_im <= w_a_im + w_b_im;
            r_bf_dn_re <= w_a_re - w_b_re;
            r_bf_dn_im <= w_a_im - w_b_im;
        end
    end

    // ROM data arrives one cycle after tw_addr, aligned with the butterfly register
    logic signed [c_prod_w-1:0] w_dr, w_di, w_wr, w_wi, w_pr, w_pi;

    assign w_dr = c_prod_w'(r_bf_dn_re);
    assign w_di = c_prod_w'(r_bf_dn_im);
    assign w_wr = c_prod_w'($signed(tw_coeff[2*NBITS_COEFF-1 -: NBITS_COEFF]));
    assign w_wi = c_prod_w'($signed(tw_coeff[NBITS_COEFF-1:0]));
    assign w_pr = (w_dr * w_wr - w_di * w_wi + c_rnd) >>> c_coeff_frac;
    assign w_pi = (w_dr * w_wi + w_di * w_wr + c_rnd) >>> c_coeff_frac;

    logic [NBITS_OUT:0] w_s_ur, w_s_ui, w_s_dr, w_s_di;

    assign w_s_ur = f_sat(c_sat_w'(r_bf_up_re));
    assign w_s_ui = f_sat(c_sat_w'(r_bf_up_im));
    assign w_s_dr = f_sat(c_sat_w'(w_pr));
    assign w_s_di = f_sat(c_sat_w'(w_pi));

    logic                   r_out_valid;
    logic                   r_ovf;
    logic [2*NBITS_OUT-1:0] r_out_up;
    logic [2*NBITS_OUT-1:0] r_out_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_up    <= '0;
            r_out_down  <= '0;
        end else begin
            r_out_valid <= r_v1;
            r_ovf       <= r_v1 & (w_s_ur[NBITS_OUT] | w_s_ui[NBITS_OUT] |
                                   w_s_dr[NBITS_OUT] | w_s_di[NBITS_OUT]);
            if (r_v1) begin
                r_out_up   <= {w_s_ur[NBITS_OUT-1:0], w_s_ui[NBITS_OUT-1:0]};
                r_out_down <= {w_s_dr[NBITS_OUT-1:0], w_s_di[NBITS_OUT-1:0]};
            end
        end
    end

    assign tw_addr   = r_tw_addr;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign out_up    = r_out_up;
    assign out_down  = r_out_down;

endmodule

`default_nettype wire

// File: tb/tb_fft_mdc_stage.sv
//==============================================================================
// Module : tb_fft_mdc_stage
// Desc   : Scoreboard bench for fft_mdc_stage (15-bit and 12-bit output instances).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_fft_mdc_stage;

    localparam int D   = 2;
    localparam int NI  = 12;
    localparam int NC  = 11;
    localparam int NO  = 15;
    localparam int NO2 = 12;
    localparam int AW  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [2*NI-1:0]  in_up, in_down;
    logic [AW-1:0]    tw_addr, tw_addr2;
    logic [2*NC-1:0]  tw_coeff, tw_coeff2;
    logic             out_valid, out_valid2, ovf, ovf2;
    logic [2*NO-1:0]  out_up, out_down;
    logic [2*NO2-1:0] out_up2, out_down2;

    fft_mdc_stage #(.NBITS_IN(NI), .NBITS_COEFF(NC), .NBITS_OUT(NO), .DELAY(D), .TW_AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_up(in_up), .in_down(in_down),
        .tw_addr(tw_addr), .tw_coeff(tw_coeff), .out_valid(out_valid),
        .out_up(out_up), .out_down(out_down), .ovf(ovf)
    );

    fft_mdc_stage #(.NBITS_IN(NI), .NBITS_COEFF(NC), .NBITS_OUT(NO2), .DELAY(D), .TW_AW(AW)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_up(in_up), .in_down(in_down),
        .tw_addr(tw_addr2), .tw_coeff(tw_coeff2), .out_valid(out_valid2),
        .out_up(out_up2), .out_down(out_down2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rom_re[4];
    int rom_im[4];
    always @(posedge clk) begin
        tw_coeff  <= {11'(rom_re[tw_addr]),  11'(rom_im[tw_addr])};
        tw_coeff2 <= {11'(rom_re[tw_addr2]), 11'(rom_im[tw_addr2])};
    end

    typedef struct {
        int               cyc;
        logic [2*NO-1:0]  up, dn;
        logic             ovf;
        logic [2*NO2-1:0] up2, dn2;
        logic             ovf2;
    } exp_t;

    exp_t sb[$];
    int   hu_re[$], hu_im[$], hd_re[$], hd_im[$];
    int   n_primed = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic void sat(input longint v, input int n, output longint r, output bit o);
        longint mx, mn;
        mx = (longint'(1) << (n - 1)) - 1;
        mn = -mx - 1;
        o  = 1'b0;
        r  = v;
        if (v > mx) begin r = mx; o = 1'b1; end
        if (v < mn) begin r = mn; o = 1'b1; end
    endfunction

    // Reference: commutator outputs computed directly from the input history by index
    task automatic model_push();
        int     k, j;
        longint cu_re, cu_im, cl_re, cl_im, bu_re, bu_im, bd_re, bd_im, wr, wi, pr, pi;
        longint r1, r2, r3, r4;
        bit     o1, o2, o3, o4;
        exp_t   e;
        k = hu_re.size() - 1;
        j = k - D;
        if (((j / D) % 2) == 1) begin cu_re = hd_re[j-D]; cu_im = hd_im[j-D]; end
        else begin cu_re = hu_re[j]; cu_im = hu_im[j]; end
        if (((k / D) % 2) == 1) begin cl_re = hu_re[k]; cl_im = hu_im[k]; end
        else begin cl_re = hd_re[k-D]; cl_im = hd_im[k-D]; end
        bu_re = cu_re + cl_re;
        bu_im = cu_im + cl_im;
        bd_re = cu_re - cl_re;
        bd_im = cu_im - cl_im;
        wr = rom_re[n_primed % 4];
        wi = rom_im[n_primed % 4];
        pr = bd_re * wr - bd_im * wi;
        pi = bd_re * wi + bd_im * wr;
`ifdef FFT_STAGE_ROUND_EN
        pr = pr + (longint'(1) << (NC - 3));
        pi = pi + (longint'(1) << (NC - 3));
`endif
        pr = pr >>> (NC - 2);
        pi = pi >>> (NC - 2);
        e.cyc = cyc + 2;
        sat(bu_re, NO, r1, o1); sat(bu_im, NO, r2, o2);
        sat(pr, NO, r3, o3);    sat(pi, NO, r4, o4);
        e.up  = {15'(r1), 15'(r2)};
        e.dn  = {15'(r3), 15'(r4)};
        e.ovf = o1 | o2 | o3 | o4;
        sat(bu_re, NO2, r1, o1); sat(bu_im, NO2, r2, o2);
        sat(pr, NO2, r3, o3);    sat(pi, NO2, r4, o4);
        e.up2  = {12'(r1), 12'(r2)};
        e.dn2  = {12'(r3), 12'(r4)};
        e.ovf2 = o1 | o2 | o3 | o4;
        sb.push_back(e);
        n_primed++;
    endtask

    task automatic step(input bit v, input int ur, input int ui, input int dr, input int di,
                        input bit r);
        rst      = r;
        in_valid = v;
        in_up    = {12'(ur), 12'(ui)};
        in_down  = {12'(dr), 12'(di)};
        if (r) begin
            hu_re.delete(); hu_im.delete(); hd_re.delete(); hd_im.delete();
            n_primed = 0;
            while (sb.size() > 0 && sb[sb.size()-1].cyc >= cyc + 1)
                sb.pop_back();
        end else if (v) begin
            hu_re.push_back(ur); hu_im.push_back(ui);
            hd_re.push_back(dr); hd_im.push_back(di);
            if (hu_re.size() > D)
                model_push();
        end
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_out_valid", 64'({out_valid, out_valid2}), 64'(0));
            chk("rst_ovf", 64'({ovf, ovf2}), 64'(0));
            chk("rst_out_up", 64'({out_up, out_up2}), 64'(0));
            chk("rst_out_down", 64'({out_down, out_down2}), 64'(0));
        end
        chk("tw_addr", 64'(tw_addr), 64'(n_primed % 4));
        chk("tw_addr2", 64'(tw_addr2), 64'(n_primed % 4));
    endtask

    task automatic set_rom(input int re, input int im);
        for (int i = 0; i < 4; i++) begin
            rom_re[i] = re;
            rom_im[i] = im;
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            me = sb.pop_front();
            chk("out_valid", 64'(out_valid), 64'(1));
            chk("out_valid2", 64'(out_valid2), 64'(1));
            chk("out_up", 64'(out_up), 64'(me.up));
            chk("out_down", 64'(out_down), 64'(me.dn));
            chk("ovf", 64'(ovf), 64'(me.ovf));
            chk("out_up2", 64'(out_up2), 64'(me.up2));
            chk("out_down2", 64'(out_down2), 64'(me.dn2));
            chk("ovf2", 64'(ovf2), 64'(me.ovf2));
        end else begin
            chk("idle_valid", 64'({out_valid, out_valid2}), 64'(0));
            chk("idle_ovf", 64'({ovf, ovf2}), 64'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_up    = '0;
        in_down  = '0;
        set_rom(512, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Constant input, continuous valid
        repeat (8) step(1, 100, 0, 50, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Same stream with a bubble after every pair
        step(0, 0, 0, 0, 0, 1);
        repeat (8) begin
            step(1, 100, 0, 50, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Twiddle -j on a difference of (40,0)
        set_rom(0, -512);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(1, ((k % 4) < 2) ? 40 : 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Full-scale input clamps the 12-bit instance
        set_rom(512, 0);
        step(0, 0, 0, 0, 0, 1);
        repeat (6) step(1, 2047, 2047, 2047, 2047, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Half-LSB products: 3*0.5 and -3*0.5
        set_rom(256, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Random data, twiddles and bubbles
        for (int i = 0; i < 4; i++) begin
            rom_re[i] = int'($urandom_range(0, 2047)) - 1024;
            rom_im[i] = int'($urandom_range(0, 2047)) - 1024;
        end
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 0);

        // Reset mid-stream, coincident with a valid input
        step(1, 1000, 1000, 1000, 1000, 1);
        for (int i = 0; i < 10; i++)
            step(1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 0);

        // Flush the tail with zero pairs
        repeat (D) step(1, 0, 0, 0, 0, 0);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            step(0, 0, 0, 0, 0, 0);
            wait_cnt++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        step(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
